delay_data_buf: RTL and testbench

Runtime-configurable delay line for debug trace data, the parametrised successor of the fixed shift-register delay in the system-diagnosis trace path. Every non-stalled cycle it accepts one word plus a valid qualifier. It returns the same word `delay+1` cycles later. Storage is a RAM-friendly ring buffer rather than a wide shift register, so large `MAX_DELAY` values map to block RAM. It sits between the event/timestamp capture stage and the trigger-qualified packetiser, so pre-trigger history reaches the packetiser intact.

---
 rtl/delay_data_buf_pkg.sv | 16 +
 rtl/delay_data_ram.sv | 48 ++++
 rtl/delay_data_buf.sv | 96 +++++++++
 tb/tb_delay_data_buf.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/delay_data_buf_pkg.sv
// Shared defaults and helpers for the debug trace delay line.
// Provides trigger-delay / timestamp width defaults and a clog2 helper.
package delay_data_buf_pkg;

    localparam int DBG_TRIGGER_DELAY   = 16;
    localparam int DBG_TIMESTAMP_WIDTH = 32;
    localparam int DBG_DATA_WIDTH      = DBG_TIMESTAMP_WIDTH + 32 + 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/delay_data_ram.sv
// Ring storage for the delay line: data RAM with one write port and a
// registered read port, plus a valid-bit flop vector clearable in one cycle.
// Ports: clk, rst, we/wa/wd/wv (write), clr (clear all valid bits),
//        re/ra (read), rd (registered read data), rv (valid bit at ra).
module delay_data_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             wv,
    input  logic             clr,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd,
    output logic             rv
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // Read returns the pre-write contents when ra == wa.
    always_ff @(posedge clk) begin
        if (rst)     rd <= '0;
        else if (re) rd <= mem[ra];
    end

    // A clear and a write in the same cycle leave only the new entry valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            if (clr) vld <= '0;
            if (we)  vld[wa] <= wv;
        end
    end

    assign rv = vld[ra];

endmodule

// File: rtl/delay_data_buf.sv
// Runtime-configurable trace delay line: word in, same word delay+1 cycles out.
// Ports: clk, rst, din/din_valid (input word), stall, flush, delay (0..MAX_DELAY),
//        dout/dout_valid (delayed word), primed (delay worth of history held).
module delay_data_buf
    import delay_data_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DBG_DATA_WIDTH,
    parameter int MAX_DELAY  = DBG_TRIGGER_DELAY,
    localparam int DLY_W     = clog2(MAX_DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DLY_W-1:0]      delay,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  primed
);

    localparam int DEPTH = MAX_DELAY;
    localparam int AW    = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [AW-1:0]         wp, wp_nxt, ra;
    logic [DLY_W-1:0]      delay_q, delay_c, fill_cnt, fill_nxt;
    logic                  chg, adv, clr, re;
    logic                  use_byp, ram_rv;
    logic [DATA_WIDTH-1:0] byp, ram_rd;

    always_comb begin
        delay_c = (delay > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : delay;
        chg     = !stall && (delay_c != delay_q);
        adv     = !stall && !flush;
        clr     = flush || chg;
        re      = adv && !chg && (delay_q != '0);
        wp_nxt  = (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
        fill_nxt = (fill_cnt == delay_q) ? fill_cnt : fill_cnt + DLY_W'(1);
        // (wp - D) mod DEPTH for 1 <= D <= DEPTH without a wide intermediate
        if (DLY_W'(wp) >= delay_q) ra = wp - AW'(delay_q);
        else                       ra = wp + AW'(DLY_W'(DEPTH) - delay_q);
    end

    delay_data_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (adv),
        .wa  (wp),
        .wd  (din),
        .wv  (din_valid),
        .clr (clr),
        .re  (re),
        .ra  (ra),
        .rd  (ram_rd),
        .rv  (ram_rv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            delay_q    <= '0;
            fill_cnt   <= '0;
            primed     <= 1'b0;
            dout_valid <= 1'b0;
            use_byp    <= 1'b0;
            byp        <= '0;
        end else begin
            if (!stall) delay_q <= delay_c;
            if (adv)    wp      <= wp_nxt;
            if (clr) begin
                fill_cnt   <= '0;
                primed     <= 1'b0;
                dout_valid <= 1'b0;
            end else if (!stall) begin
                fill_cnt <= fill_nxt;
                primed   <= (fill_nxt == delay_q);
                use_byp  <= (delay_q == '0);
                if (delay_q == '0) begin
                    byp        <= din;
                    dout_valid <= din_valid;
                end else begin
                    dout_valid <= ram_rv;
                end
            end
        end
    end

    // Both sources are flops; the select is frozen with them on stall.
    assign dout = use_byp ? byp : ram_rd;

endmodule

// File: tb/tb_delay_data_buf.sv
// Self-checking bench for delay_data_buf (MAX_DELAY=16, 16-bit data).
// Scoreboard of due words plus a bypass vector table and corner sequences.
module tb_delay_data_buf;

    localparam int DW  = 16;
    localparam int MD  = 16;
    localparam int DLW = 5;

    logic           clk;
    logic           rst;
    logic [DW-1:0]  din;
    logic           din_valid;
    logic           stall;
    logic           flush;
    logic [DLW-1:0] delay;
    logic [DW-1:0]  dout;
    logic           dout_valid;
    logic           primed;

    delay_data_buf #(
        .DATA_WIDTH (DW),
        .MAX_DELAY  (MD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .stall      (stall),
        .flush      (flush),
        .delay      (delay),
        .dout       (dout),
        .dout_valid (dout_valid),
        .primed     (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    typedef struct {
        logic [DW-1:0] din;
        logic          vld;
        logic [DW-1:0] exp_dout;
        logic          exp_dv;
        logic          exp_primed;
    } vec_t;

    sb_t     sbq[$];
    vec_t    tbl[4];
    int      checks   = 0;
    int      failures = 0;
    int      acnt     = 0;
    int      dq_m     = 0;
    logic [DW-1:0] last_dout;
    logic    last_dv;
    logic    last_pr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic sample_last();
        last_dout = dout;
        last_dv   = dout_valid;
        last_pr   = primed;
    endtask

    task automatic do_reset();
        rst = 1'b1; din = '0; din_valid = 1'b0;
        stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk("reset_dout", 32'(dout), 0);
        chk("reset_valid", 32'(dout_valid), 0);
        chk("reset_primed", 32'(primed), 0);
        rst = 1'b0;
        sbq.delete();
        dq_m = 0;
        sample_last();
    endtask

    task automatic cyc(input logic [DW-1:0] d, input logic v,
                       input logic s, input logic f, input int dly);
        int   dc;
        logic chg;
        dc  = (dly > MD) ? MD : dly;
        chg = !s && !f && (dc != dq_m);
        din = d; din_valid = v; stall = s; flush = f;
        delay = DLW'(dly);
        if (f) begin
            sbq.delete();
        end else if (!s) begin
            acnt++;
            if (chg) sbq.delete();
            if (v) sbq.push_back('{data: d, due: acnt + dc});
        end
        if (!s) dq_m = dc;
        @(posedge clk); #1;
        if (f || chg) begin
            chk("clear_valid", 32'(dout_valid), 0);
            chk("clear_primed", 32'(primed), 0);
        end else if (s) begin
            chk("stall_dout", 32'(dout), 32'(last_dout));
            chk("stall_valid", 32'(dout_valid), 32'(last_dv));
            chk("stall_primed", 32'(primed), 32'(last_pr));
        end else if (sbq.size() > 0 && sbq[0].due == acnt) begin
            chk("sb_valid", 32'(dout_valid), 1);
            chk("sb_data", 32'(dout), 32'(sbq[0].data));
            void'(sbq.pop_front());
        end else begin
            chk("sb_idle_valid", 32'(dout_valid), 0);
        end
        sample_last();
    endtask

    initial begin
        tbl[0] = '{16'h1234, 1'b1, 16'h1234, 1'b1, 1'b1};
        tbl[1] = '{16'hABCD, 1'b0, 16'hABCD, 1'b0, 1'b1};
        tbl[2] = '{16'h0001, 1'b1, 16'h0001, 1'b1, 1'b1};
        tbl[3] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1};

        delay = '0;
        do_reset();

        // D=0 bypass: previous-cycle input on the output, primed at once
        for (int i = 0; i < 4; i++) begin
            cyc(tbl[i].din, tbl[i].vld, 1'b0, 1'b0, 0);
            chk("tbl_dout", 32'(dout), 32'(tbl[i].exp_dout));
            chk("tbl_valid", 32'(dout_valid), 32'(tbl[i].exp_dv));
            chk("tbl_primed", 32'(primed), 32'(tbl[i].exp_primed));
        end

        // D=5 counting stream, primed after the 5th word
        cyc('0, 1'b0, 1'b0, 1'b0, 5);
        for (int w = 1; w <= 30; w++) begin
            cyc(DW'(w), 1'b1, 1'b0, 1'b0, 5);
            if (w == 4) chk("primed_w4", 32'(primed), 0);
            if (w == 5) chk("primed_w5", 32'(primed), 1);
            if (w == 6) chk("first_out", 32'(dout), 1);
        end

        // stall 3 cycles; delay wiggled while stalled must not clear
        for (int i = 0; i < 3; i++)
            cyc(DW'($urandom_range(1000, 2000)), 1'b1, 1'b1, 1'b0, 7);
        for (int w = 31; w <= 40; w++) cyc(DW'(w), 1'b1, 1'b0, 1'b0, 5);

        // switch 5 -> 3 mid-stream
        for (int w = 41; w <= 50; w++) cyc(DW'(w), 1'b1, 1'b0, 1'b0, 3);

        // flush with stall, then plain flush
        cyc(16'd51, 1'b1, 1'b1, 1'b1, 3);
        for (int w = 52; w <= 60; w++) cyc(DW'(w), 1'b1, 1'b0, 1'b0, 3);
        cyc(16'd61, 1'b1, 1'b0, 1'b1, 3);
        for (int w = 62; w <= 70; w++) cyc(DW'(w), 1'b1, 1'b0, 1'b0, 3);

        // delay=31 clamps to 16; later delay=16 is no change
        cyc('0, 1'b0, 1'b0, 1'b0, 31);
        for (int w = 100; w < 160; w++)
            cyc(DW'(w), (w % 7) != 3, 1'b0, 1'b0, 31);
        for (int w = 160; w <= 180; w++) cyc(DW'(w), 1'b1, 1'b0, 1'b0, 16);

        // reset mid-stream, restart with D=2
        do_reset();
        for (int w = 200; w <= 210; w++) cyc(DW'(w), 1'b1, 1'b0, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
